l1_cache: RTL and testbench
===========================

// Module: l1_cache
// PURPOSE
//  Set-associative, write-back, write-allocate L1 data cache with an embedded behavioural backing memory.
//  Serves one word read or write per cycle and reports hit/miss, the read data, and the backing-memory word.
//  Sits between a core load/store port and main memory; the embedded memory keeps it self-contained for unit verification.
// PARAMETERS
//  NUM_LINES     4   ways per set.
//  NUM_SETS      4   number of sets; must equal 2**INDEX_WIDTH.
//  BLOCK_SIZE    32  bits per block word; must equal LINE_WIDTH.
//  SIZE          NUM_SETS*NUM_LINES*(2**OFFSET_WIDTH)*BLOCK_SIZE   total data bits; informational only.
//  LINE_WIDTH    32  address and data width.
//  INDEX_WIDTH   2   set-index bits, addr[OFFSET_WIDTH+:INDEX_WIDTH].
//  OFFSET_WIDTH  1   word-in-block bits, addr[OFFSET_WIDTH-1:0]; block = 2**OFFSET_WIDTH words.
//  TAG_WIDTH     29  tag bits, addr[LINE_WIDTH-1 -: TAG_WIDTH].
//  MEM_AW        8   backing-memory word-address bits; uses addr[MEM_AW-1:0].
//  Elaboration-time check: TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH == LINE_WIDTH.
// PORTS
//  clk       in   1           clock, rising edge.
//  rst_n     in   1           asynchronous active-low reset.
//  wren      in   1           write request.
//  rden      in   1           read request.
//  addr      in   LINE_WIDTH  word address.
//  data_in   in   LINE_WIDTH  write data.
//  cache_hit out  1           registered: last request hit.
//  data_out  out  LINE_WIDTH  registered: word read or written.
//  mem_out   out  LINE_WIDTH  registered: backing-memory word at addr after the access.
// BEHAVIOUR
//  Reset: clears all valid and dirty bits, replacement state, and backing memory.
//  Reset: drives cache_hit=0, data_out=0, mem_out=0.
//  Reset asserted mid-operation aborts the access; no partial writes persist.
//  Request sampled on rising clk. wren has priority when both wren and rden are high; the access is a write.
//  No request: all outputs and state hold.
//  Latency: 1 cycle for hit and miss alike; results are visible after the sampling edge. No stall, always ready.
//  Hit: a valid way in the set has a matching tag.
//   cache_hit<=1. Read: data_out<=word. Write: update the word, set dirty, data_out<=data_in.
//  Miss: cache_hit<=0. Choose a victim: an invalid way first (lowest index), else the replacement policy.
//   If the victim is valid and dirty, write its whole block back to memory before refilling.
//   Refill the full block from memory combinationally, set valid, clear dirty.
//   Then complete as a hit (write sets dirty).
//  mem_out <= memory[addr] after any write-back; a write hit does not change memory.
//  Replacement state is updated on every hit and every fill.
// CONFIGURATION
//  CACHE_LRU_EN defined: true LRU per set (age counters); the least-recently-used way is evicted.
//  CACHE_LRU_EN undefined: per-set round-robin pointer, advanced on each fill (FIFO).
// STRUCTURE
//  Package l1_cache_pkg: line struct (valid, dirty, tag, data[2**OFFSET_WIDTH]), address-field helpers, replacement-state type.
//  One sub-module: l1_cache_repl, the per-set victim selector.
//   l1_cache_repl switches between LRU and round-robin on CACHE_LRU_EN.
//  Tag/data arrays, hit logic and the backing memory stay in the top module.
// TESTING
//  1 Reset low -> cache_hit=0, data_out=0, mem_out=0.
//  2 rden addr=0x10 cold -> cache_hit=0, data_out=0; repeat rden 0x10 -> cache_hit=1.
//  3 wren 0x10 data=0xDEADBEEF -> cache_hit=1, mem_out=0 (write-back).
//    then rden 0x10 -> cache_hit=1, data_out=0xDEADBEEF.
//  4 wren 0x11 data=0x5, then rden 0x10 -> cache_hit=1 (same block), data_out=0xDEADBEEF.
//  5 After 2-4, rden 0x18, 0x20, 0x28, 0x30 (all set 0) -> 0x30 misses and evicts 0x10.
//    Dirty write-back of 0x10 happens. rden 0x10 -> cache_hit=0, data_out=0xDEADBEEF, mem_out=0xDEADBEEF.
//  6 rden and wren together on 0x40 data=0x7 -> treated as write; rden 0x40 -> data_out=0x7.
//    Reset pulse, then rden 0x40 -> cache_hit=0.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: geometry, line/address types and address-field helpers for l1_cache.
package l1_cache_pkg;

  localparam int unsigned NUM_LINES    = 4;
  localparam int unsigned NUM_SETS     = 4;
  localparam int unsigned BLOCK_SIZE   = 32;
  localparam int unsigned LINE_WIDTH   = 32;
  localparam int unsigned INDEX_WIDTH  = 2;
  localparam int unsigned OFFSET_WIDTH = 1;
  localparam int unsigned TAG_WIDTH    = 29;
  localparam int unsigned MEM_AW       = 8;
  localparam int unsigned WORDS        = 2 ** OFFSET_WIDTH;
  localparam int unsigned SIZE         = NUM_SETS * NUM_LINES * WORDS * BLOCK_SIZE;
  localparam int unsigned WAY_W        = $clog2(NUM_LINES);
  localparam int unsigned MEM_DEPTH    = 2 ** MEM_AW;

  typedef logic [LINE_WIDTH-1:0]   word_t;
  typedef logic [TAG_WIDTH-1:0]    tag_t;
  typedef logic [INDEX_WIDTH-1:0]  idx_t;
  typedef logic [OFFSET_WIDTH-1:0] off_t;
  typedef logic [WAY_W-1:0]        way_t;
  typedef logic [MEM_AW-1:0]       mem_addr_t;

  // Per-way age (LRU) or per-set pointer (round-robin).
  typedef logic [WAY_W-1:0] repl_state_t;

  typedef struct packed {
    logic                             valid;
    logic                             dirty;
    tag_t                             tag;
    logic [WORDS-1:0][LINE_WIDTH-1:0] data;
  } line_t;

  function automatic tag_t addr_tag(word_t a);
    return a[LINE_WIDTH-1 -: TAG_WIDTH];
  endfunction

  function automatic idx_t addr_idx(word_t a);
    return a[OFFSET_WIDTH +: INDEX_WIDTH];
  endfunction

  function automatic off_t addr_off(word_t a);
    return a[OFFSET_WIDTH-1:0];
  endfunction

  function automatic word_t blk_addr(tag_t t, idx_t i, off_t o);
    return {t, i, o};
  endfunction

  function automatic mem_addr_t mem_addr(word_t a);
    return MEM_AW'(a);
  endfunction

endpackage

// File: rtl/l1_cache_if.sv
// l1_cache_if: core-side request/response bundle of l1_cache.
interface l1_cache_if;
  import l1_cache_pkg::*;

  logic  wren;
  logic  rden;
  word_t addr;
  word_t data_in;
  logic  cache_hit;
  word_t data_out;
  word_t mem_out;

  modport master (output wren, rden, addr, data_in, input cache_hit, data_out, mem_out);
  modport slave  (input wren, rden, addr, data_in, output cache_hit, data_out, mem_out);
endinterface

// File: rtl/l1_cache_repl.sv
// l1_cache_repl: per-set victim selector. Define CACHE_LRU_EN for true LRU
// (age counters); otherwise a per-set round-robin pointer advanced on each fill.
module l1_cache_repl
  import l1_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  idx_t                 set_i,
  input  logic                 touch_i,
  input  logic                 miss_i,
`ifdef CACHE_LRU_EN
  input  way_t                 hit_way_i,
`endif
  input  logic [NUM_LINES-1:0] valid_i,
  output way_t                 victim_way_c_o
);

  way_t policy_c;
  logic found_c;

  // Victim: lowest-index invalid way, else the policy's choice.
  always_comb begin
    victim_way_c_o = policy_c;
    found_c        = 1'b0;
    for (int w = 0; w < NUM_LINES; w++) begin
      if (!valid_i[w] && !found_c) begin
        victim_way_c_o = way_t'(w);
        found_c        = 1'b1;
      end
    end
  end

`ifdef CACHE_LRU_EN
  repl_state_t age_q [NUM_SETS][NUM_LINES];
  way_t        touched_c;

  assign touched_c = miss_i ? victim_way_c_o : hit_way_i;

  // Oldest way (age == NUM_LINES-1) is the LRU candidate.
  always_comb begin
    policy_c = '0;
    for (int w = 0; w < NUM_LINES; w++) begin
      if (age_q[set_i][w] == repl_state_t'(NUM_LINES - 1)) policy_c = way_t'(w);
    end
  end

  // Touched way becomes youngest; younger ways age by one, keeping a permutation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_LINES; w++)
          age_q[s][w] <= repl_state_t'(w);
    end else if (touch_i) begin
      for (int w = 0; w < NUM_LINES; w++) begin
        if (way_t'(w) == touched_c)
          age_q[set_i][w] <= '0;
        else if (age_q[set_i][w] < age_q[set_i][touched_c])
          age_q[set_i][w] <= age_q[set_i][w] + repl_state_t'(1);
      end
    end
  end
`else
  repl_state_t ptr_q [NUM_SETS];

  assign policy_c = ptr_q[set_i];

  // FIFO pointer advances on every fill of the set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
    end else if (touch_i && miss_i) begin
      ptr_q[set_i] <= ptr_q[set_i] + repl_state_t'(1);
    end
  end
`endif

endmodule

// File: rtl/l1_cache.sv
// l1_cache: set-associative write-back/write-allocate L1 data cache with an
// embedded backing memory; single-cycle access. CACHE_LRU_EN selects LRU replacement.
module l1_cache
  import l1_cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  l1_cache_if.slave  bus
);

  if (TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH != LINE_WIDTH) begin : g_chk_addr
    $error("l1_cache: address fields do not sum to LINE_WIDTH");
  end
  if (NUM_SETS != 2 ** INDEX_WIDTH || BLOCK_SIZE != LINE_WIDTH) begin : g_chk_geom
    $error("l1_cache: inconsistent cache geometry");
  end

  line_t     lines_q [NUM_SETS][NUM_LINES];
  word_t     mem_q   [MEM_DEPTH];
  logic      hit_q;
  word_t     data_out_q;
  word_t     mem_out_q;

  logic      req_c, hit_c, wb_en_c;
  tag_t      tag_c;
  idx_t      idx_c;
  off_t      off_c;
  way_t      hit_way_c, victim_c, way_c;
  logic [NUM_LINES-1:0] valid_c;
  line_t     victim_line_c, line_d;
  mem_addr_t wb_addr_c   [WORDS];
  mem_addr_t fill_addr_c [WORDS];
  word_t     fill_word_c [WORDS];
  word_t     mem_out_d;

  assign req_c = bus.wren | bus.rden;
  assign tag_c = addr_tag(bus.addr);
  assign idx_c = addr_idx(bus.addr);
  assign off_c = addr_off(bus.addr);

  // Tag compare across the ways of the addressed set.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    valid_c   = '0;
    for (int w = 0; w < NUM_LINES; w++) begin
      valid_c[w] = lines_q[idx_c][w].valid;
      if (lines_q[idx_c][w].valid && lines_q[idx_c][w].tag == tag_c && !hit_c) begin
        hit_c     = 1'b1;
        hit_way_c = way_t'(w);
      end
    end
  end

  l1_cache_repl u_repl (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_i          (idx_c),
    .touch_i        (req_c),
    .miss_i         (~hit_c),
`ifdef CACHE_LRU_EN
    .hit_way_i      (hit_way_c),
`endif
    .valid_i        (valid_c),
    .victim_way_c_o (victim_c)
  );

  assign way_c         = hit_c ? hit_way_c : victim_c;
  assign victim_line_c = lines_q[idx_c][victim_c];
  assign wb_en_c       = req_c & ~hit_c & victim_line_c.valid & victim_line_c.dirty;

  // Memory word addresses of the evicted block and the block being filled.
  always_comb begin
    for (int w = 0; w < WORDS; w++) begin
      wb_addr_c[w]   = mem_addr(blk_addr(victim_line_c.tag, idx_c, off_t'(w)));
      fill_addr_c[w] = mem_addr(blk_addr(tag_c, idx_c, off_t'(w)));
    end
  end

  // Memory as it reads after the write-back, for the refill and mem_out.
  always_comb begin
    for (int w = 0; w < WORDS; w++) begin
      fill_word_c[w] = mem_q[fill_addr_c[w]];
      for (int v = 0; v < WORDS; v++)
        if (wb_en_c && wb_addr_c[v] == fill_addr_c[w]) fill_word_c[w] = victim_line_c.data[v];
    end
    mem_out_d = mem_q[mem_addr(bus.addr)];
    for (int v = 0; v < WORDS; v++)
      if (wb_en_c && wb_addr_c[v] == mem_addr(bus.addr)) mem_out_d = victim_line_c.data[v];
  end

  // Next contents of the accessed way: refill on miss, then apply the write.
  always_comb begin
    line_d = lines_q[idx_c][way_c];
    if (!hit_c) begin
      line_d.valid = 1'b1;
      line_d.dirty = 1'b0;
      line_d.tag   = tag_c;
      for (int w = 0; w < WORDS; w++) line_d.data[w] = fill_word_c[w];
    end
    if (bus.wren) begin
      line_d.data[off_c] = bus.data_in;
      line_d.dirty       = 1'b1;
    end
  end

  // Arrays, backing memory and registered outputs; idle cycles hold everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_LINES; w++)
          lines_q[s][w] <= '0;
      for (int m = 0; m < MEM_DEPTH; m++) mem_q[m] <= '0;
      hit_q      <= 1'b0;
      data_out_q <= '0;
      mem_out_q  <= '0;
    end else if (req_c) begin
      lines_q[idx_c][way_c] <= line_d;
      if (wb_en_c)
        for (int v = 0; v < WORDS; v++) mem_q[wb_addr_c[v]] <= victim_line_c.data[v];
      hit_q      <= hit_c;
      data_out_q <= line_d.data[off_c];
      mem_out_q  <= mem_out_d;
    end
  end

  assign bus.cache_hit = hit_q;
  assign bus.data_out  = data_out_q;
  assign bus.mem_out   = mem_out_q;

endmodule

// File: tb/tb_l1_cache.sv
// tb_l1_cache: directed vectors with a scoreboard queue and a decoupled monitor.
module tb_l1_cache;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] data;
    logic [31:0] mem;
  } exp_t;

  logic clk;
  logic rst_n;
  logic observe;
  logic pend;
  int   n_vec;
  int   n_miss;
  exp_t exp_q [$];

  l1_cache_if bus ();

  l1_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A vector's result is due at the negedge after the edge that sampled it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= bus.wren | bus.rden | observe;
  end

  // Monitor: pop the oldest expectation whenever a result is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_result: no expectation queued, hit=%0b data=%h", bus.cache_hit, bus.data_out);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if (bus.cache_hit !== e.hit) begin
            n_miss++;
            $display("FAIL %s cache_hit: got %0b want %0b", e.name, bus.cache_hit, e.hit);
          end
          if (bus.data_out !== e.data) begin
            n_miss++;
            $display("FAIL %s data_out: got %h want %h", e.name, bus.data_out, e.data);
          end
          if (bus.mem_out !== e.mem) begin
            n_miss++;
            $display("FAIL %s mem_out: got %h want %h", e.name, bus.mem_out, e.mem);
          end
        end
      end
    end
  end

  task automatic apply(input string nm, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic eh, input logic [31:0] ed, input logic [31:0] em);
    exp_t e;
    @(negedge clk);
    bus.wren    = wr;
    bus.rden    = rd;
    bus.addr    = a;
    bus.data_in = d;
    observe     = !(wr || rd);
    e.name = nm;
    e.hit  = eh;
    e.data = ed;
    e.mem  = em;
    exp_q.push_back(e);
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.wren = 1'b0;
    bus.rden = 1'b0;
    observe  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    rst_n       = 1'b0;
    observe     = 1'b0;
    bus.wren    = 1'b0;
    bus.rden    = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    //     name            wr    rd    addr   data          hit   data_out      mem_out
    apply("reset_state",   1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 32'h0,        32'h0);
    apply("rd10_cold",     1'b0, 1'b1, 32'h10, 32'h0,       1'b0, 32'h0,        32'h0);
    apply("rd10_warm",     1'b0, 1'b1, 32'h10, 32'h0,       1'b1, 32'h0,        32'h0);
    apply("wr10_hit",      1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0);
    apply("rd10_after_wr", 1'b0, 1'b1, 32'h10, 32'h0,       1'b1, 32'hDEADBEEF, 32'h0);
    apply("wr11_sameblk",  1'b1, 1'b0, 32'h11, 32'h5,       1'b1, 32'h5,        32'h0);
    apply("rd10_sameblk",  1'b0, 1'b1, 32'h10, 32'h0,       1'b1, 32'hDEADBEEF, 32'h0);
    apply("idle_hold",     1'b0, 1'b0, 32'h10, 32'h0,       1'b1, 32'hDEADBEEF, 32'h0);
    apply("rd18_fill",     1'b0, 1'b1, 32'h18, 32'h0,       1'b0, 32'h0,        32'h0);
    apply("rd20_fill",     1'b0, 1'b1, 32'h20, 32'h0,       1'b0, 32'h0,        32'h0);
    apply("rd28_fill",     1'b0, 1'b1, 32'h28, 32'h0,       1'b0, 32'h0,        32'h0);
    apply("rd30_evict10",  1'b0, 1'b1, 32'h30, 32'h0,       1'b0, 32'h0,        32'h0);
    apply("rd10_refill",   1'b0, 1'b1, 32'h10, 32'h0,       1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
    apply("rd11_wb_word",  1'b0, 1'b1, 32'h11, 32'h0,       1'b1, 32'h5,        32'h5);
    apply("wrrd40_prio",   1'b1, 1'b1, 32'h40, 32'h7,       1'b0, 32'h7,        32'h0);
    apply("rd40_hit",      1'b0, 1'b1, 32'h40, 32'h0,       1'b1, 32'h7,        32'h0);
    apply("wr50_wmiss",    1'b1, 1'b0, 32'h50, 32'h99,      1'b0, 32'h99,       32'h0);
    apply("rd58_fill",     1'b0, 1'b1, 32'h58, 32'h0,       1'b0, 32'h0,        32'h0);
    apply("rd60_fill",     1'b0, 1'b1, 32'h60, 32'h0,       1'b0, 32'h0,        32'h0);
    apply("rd68_evict40",  1'b0, 1'b1, 32'h68, 32'h0,       1'b0, 32'h0,        32'h0);
    apply("rd40_refill",   1'b0, 1'b1, 32'h40, 32'h0,       1'b0, 32'h7,        32'h7);
    apply("rd50_refill",   1'b0, 1'b1, 32'h50, 32'h0,       1'b0, 32'h99,       32'h99);
    apply("wr03_set1",     1'b1, 1'b0, 32'h03, 32'hA5,      1'b0, 32'hA5,       32'h0);
    apply("rd02_set1",     1'b0, 1'b1, 32'h02, 32'h0,       1'b1, 32'h0,        32'h0);
    apply("rd03_set1",     1'b0, 1'b1, 32'h03, 32'h0,       1'b1, 32'hA5,       32'h0);

    // Reset lands on top of an in-flight write; nothing from it may persist.
    @(negedge clk);
    bus.wren    = 1'b1;
    bus.rden    = 1'b0;
    bus.addr    = 32'h10;
    bus.data_in = 32'h1234;
    observe     = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    bus.wren = 1'b0;
    rst_n    = 1'b1;

    apply("post_rst_state", 1'b0, 1'b0, 32'h0, 32'h0,       1'b0, 32'h0,        32'h0);
    apply("post_rst_rd10",  1'b0, 1'b1, 32'h10, 32'h0,      1'b0, 32'h0,        32'h0);
    apply("post_rst_rd40",  1'b0, 1'b1, 32'h40, 32'h0,      1'b0, 32'h0,        32'h0);
    go_idle();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations still queued, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
